// File: rtl/next_pc_unit.sv
// next_pc_unit: registered program counter for the KGPminiRISC fetch stage.
// Selects the next PC from sequential, branch, jump, call and return sources
// and keeps a circular return-address stack (RAS) for call/return pairs.
// Optional feature macro: PC_ALIGN_CHECK_EN. When defined, selected targets
// have their low log2(STEP) bits cleared and MisalignErr pulses if any were set.
module next_pc_unit #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             JCout,
    input  logic             UncondJump,
    input  logic             Call,
    input  logic             Ret,
    input  logic [WIDTH-1:0] JumpAddr,
    output logic [WIDTH-1:0] PC,
    output logic             RASEmpty,
    output logic             RASFull,
    output logic             RASOverflow,
    output logic             RetUnderflow,
    output logic             MisalignErr
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    // top_q points at the slot the next push writes; the live top entry sits
    // one slot below it (circularly). A push while full lands on the oldest.
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             undf_q, undf_d;

    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] selTarget;
    logic             takeTarget;
    logic [PW-1:0]    topIdx;
    logic [PW-1:0]    nextPtr;
    logic             rasEmpty;
    logic             rasFull;
    logic             rasWe;
    logic [PW-1:0]    rasWaddr;
    logic [WIDTH-1:0] rasWdata;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
    logic mis_q, mis_d;
`endif

    assign rasEmpty = (count_q == '0);
    assign rasFull  = (count_q == CW'(RAS_DEPTH));

    // Next-PC selection, RAS pointer/count update and flag generation.
    always_comb begin
        seq        = pc_q + WIDTH'(STEP);
        topIdx     = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - 1'b1;
        nextPtr    = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
        pc_d       = pc_q;
        top_d      = top_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        undf_d     = 1'b0;
        rasWe      = 1'b0;
        rasWaddr   = top_q;
        rasWdata   = seq;
        target     = JumpAddr;
        takeTarget = 1'b0;
        if (!Stall) begin
            pc_d = seq;
            if (Ret && !rasEmpty) begin
                target     = ras_q[topIdx];
                takeTarget = 1'b1;
                if (Call) begin
                    rasWe    = 1'b1;
                    rasWaddr = topIdx;
                end else begin
                    top_d   = topIdx;
                    count_d = count_q - 1'b1;
                end
            end else begin
                undf_d = Ret;
                if (Call) begin
                    rasWe      = 1'b1;
                    rasWaddr   = top_q;
                    top_d      = nextPtr;
                    takeTarget = 1'b1;
                    if (rasFull) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else if (UncondJump || JCout) begin
                    takeTarget = 1'b1;
                end
            end
        end
`ifdef PC_ALIGN_CHECK_EN
        selTarget = target & ~ALIGN_MASK;
        mis_d     = takeTarget && (|(target & ALIGN_MASK));
`else
        selTarget = target;
`endif
        if (takeTarget) begin
            pc_d = selTarget;
        end
    end

    // Architectural state and flag registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            undf_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            undf_q  <= undf_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Registered misalignment pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign MisalignErr = mis_q;
`else
    assign MisalignErr = 1'b0;
`endif

    // RAS storage; contents are don't-care after reset so no reset is needed.
    always_ff @(posedge clk) begin
        if (rasWe) begin
            ras_q[rasWaddr] <= rasWdata;
        end
    end

    assign PC           = pc_q;
    assign RASEmpty     = rasEmpty;
    assign RASFull      = rasFull;
    assign RASOverflow  = ovf_q;
    assign RetUnderflow = undf_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: scoreboard bench for next_pc_unit (WIDTH=32, STEP=4,
// RAS_DEPTH=4, RESET_PC=0). A behavioural model with a queue-based stack
// predicts each cycle; predictions are queued and popped after the edge.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, JCout, UncondJump, Call, Ret;
    logic [31:0] JumpAddr;
    logic [31:0] PC;
    logic        RASEmpty, RASFull, RASOverflow, RetUnderflow, MisalignErr;

    typedef struct packed {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        undf;
        logic        mis;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] mStack[$];
    logic [31:0] mPc;
    logic        mOvf;
    int          checks   = 0;
    int          failures = 0;

    next_pc_unit #(
        .WIDTH(32),
        .STEP(4),
        .RAS_DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Stall(Stall),
        .JCout(JCout),
        .UncondJump(UncondJump),
        .Call(Call),
        .Ret(Ret),
        .JumpAddr(JumpAddr),
        .PC(PC),
        .RASEmpty(RASEmpty),
        .RASFull(RASFull),
        .RASOverflow(RASOverflow),
        .RetUnderflow(RetUnderflow),
        .MisalignErr(MisalignErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic compareOutputs();
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput("pc", PC, e.pc);
            checkOutput("ras_empty", 32'(RASEmpty), 32'(e.empty));
            checkOutput("ras_full", 32'(RASFull), 32'(e.full));
            checkOutput("ras_overflow", 32'(RASOverflow), 32'(e.ovf));
            checkOutput("ret_underflow", 32'(RetUnderflow), 32'(e.undf));
            checkOutput("misalign", 32'(MisalignErr), 32'(e.mis));
        end
    endtask

    // Drive one cycle of inputs (caller is away from the rising edge), predict, then compare after the edge.
    task automatic applyStimulus(input logic st, input logic jc, input logic uj,
                                 input logic ca, input logic re, input logic [31:0] addr);
        exp_t        e;
        logic [31:0] seq;
        logic [31:0] tgt;
        logic        take;
        Stall      = st;
        JCout      = jc;
        UncondJump = uj;
        Call       = ca;
        Ret        = re;
        JumpAddr   = addr;
        seq  = mPc + 32'd4;
        tgt  = addr;
        take = 1'b0;
        e    = '0;
        if (!st) begin
            if (re && mStack.size() > 0) begin
                tgt  = mStack[mStack.size() - 1];
                take = 1'b1;
                if (ca) mStack[mStack.size() - 1] = seq;
                else    void'(mStack.pop_back());
            end else begin
                e.undf = re;
                if (ca) begin
                    if (mStack.size() == 4) begin
                        void'(mStack.pop_front());
                        mOvf = 1'b1;
                    end
                    mStack.push_back(seq);
                    take = 1'b1;
                end else if (uj || jc) begin
                    take = 1'b1;
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            if (take && tgt[1:0] != 2'b00) begin
                e.mis    = 1'b1;
                tgt[1:0] = 2'b00;
            end
`endif
            mPc = take ? tgt : seq;
        end
        e.pc    = mPc;
        e.empty = (mStack.size() == 0);
        e.full  = (mStack.size() == 4);
        e.ovf   = mOvf;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        compareOutputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic jumpTo(input logic [31:0] a);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a);
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        Stall      = 1'b0;
        JCout      = 1'b0;
        UncondJump = 1'b0;
        Call       = 1'b0;
        Ret        = 1'b0;
        JumpAddr   = 32'h0;
        mPc        = 32'h0;
        mOvf       = 1'b0;
        mStack.delete();
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pc", PC, 32'h0);
        checkOutput("reset_empty", 32'(RASEmpty), 32'd1);
        checkOutput("reset_full", 32'(RASFull), 32'd0);
        checkOutput("reset_overflow", 32'(RASOverflow), 32'd0);
        checkOutput("reset_underflow", 32'(RetUnderflow), 32'd0);
        checkOutput("reset_misalign", 32'(MisalignErr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        doReset();

        // Sequential: 4, 8, 12
        idle(3);

        // Jump and stall
        jumpTo(32'h10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        idle(1);

        // Call then return
        jumpTo(32'h20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Overflow with five nested calls, then five returns with underflow
        jumpTo(32'h0);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'(i * 32'h100));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        idle(1);

        // Asynchronous reset between clock edges
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h700);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pc", PC, 32'h0);
        checkOutput("async_reset_empty", 32'(RASEmpty), 32'd1);
        checkOutput("async_reset_overflow", 32'(RASOverflow), 32'd0);
        doReset();

        // Wrap-around from the top of the address space
        jumpTo(32'hFFFF_FFFC);
        idle(1);

        // Ret+Call with top entry 0x50 at PC 0x80, then plain Ret gives 0x84
        jumpTo(32'h4C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h900);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Ret+Call with empty RAS: underflow pulse plus a normal call
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Misaligned jump target
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h103);
        idle(1);

        // Randomised mix of all controls
        jumpTo(32'h1000);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, a);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Registered program-counter unit for the KGPminiRISC fetch stage. It holds the architectural PC, selects the next PC each cycle from sequential, conditional, unconditional, call and return sources, and keeps a parametrised return-address stack (RAS) for call/return pairs. It replaces the purely combinational next-PC selection with a stateful, stallable PC register.

## Interface
Parameters:
- WIDTH, 32: PC and address width in bits.
- STEP, 4: sequential increment. Must be a power of two, ≥1.
- RAS_DEPTH, 4: number of RAS entries. Must be ≥2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Stall  in  1  holds all state when high.
- JCout  in  1  conditional-branch taken.
- UncondJump  in  1  unconditional jump.
- Call  in  1  jump-and-link: push the return address, then jump.
- Ret  in  1  return: pop the RAS and jump to the popped address.
- JumpAddr  in  WIDTH  target for jump and call.
- PC  out  WIDTH  current PC (registered).
- RASEmpty  out  1  RAS count == 0.
- RASFull  out  1  RAS count == RAS_DEPTH.
- RASOverflow  out  1  sticky; set when a push overwrote a live entry.
- RetUnderflow  out  1  one-cycle pulse; Ret issued while the RAS was empty.
- MisalignErr  out  1  one-cycle pulse; alignment error (see Configuration).

## Operation
- Reset values: PC=RESET_PC, RAS count=0, top pointer=0, RASOverflow=0, RetUnderflow=0, MisalignErr=0. RAS entry contents are don't-care.
- Seq = (PC + STEP) mod 2^WIDTH. Wrap-around from all-ones is legal and silent.
- Next-PC priority per cycle when Stall=0:
  1. Ret and RAS not empty: PC←top entry; count−1.
  2. Ret and RAS empty: PC←Seq; RetUnderflow=1 for the next cycle; RAS unchanged. A simultaneous Call is then handled as in rule 4.
  3. Ret and Call, RAS not empty: PC←top entry; the top entry is replaced with Seq; count unchanged.
  4. Call: push Seq; PC←JumpAddr.
  5. UncondJump or JCout: PC←JumpAddr.
  6. Otherwise: PC←Seq.
- RAS is circular with RAS_DEPTH entries. A push while full overwrites the oldest entry, the count stays at RAS_DEPTH, and RASOverflow sets. RASOverflow clears only on reset.
- Stall=1: PC, RAS, count and flags hold. Call, Ret and jump inputs are ignored and not queued. Pulse outputs drop to 0.
- Reset asserted mid-operation clears state immediately, regardless of clk. The first update after release uses PC=RESET_PC.

## Timing
- PC is a register. Inputs sampled at edge n take effect on PC after edge n, so next-PC latency is 1 cycle. There is no combinational path from inputs to PC.
- RASEmpty and RASFull are decoded from the registered count and are valid in the same cycle as PC.
- RetUnderflow and MisalignErr are registered pulses, high for exactly the cycle after the offending edge.
- Back-to-back Call/Ret on consecutive cycles is supported at full rate with no bubbles.

## Configuration
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - A selected target (JumpAddr, or the popped entry) with any of its low log2(STEP) bits nonzero is loaded with those bits cleared, and MisalignErr pulses.
  - Pushed return addresses are always aligned when PC is aligned.
  - With STEP=1 there are no low bits, so MisalignErr never fires.
- Undefined:
  - Targets are loaded unmodified.
  - MisalignErr is tied to 0.

## Test plan
- Reset and sequential: rst_n low then released, 3 cycles idle -> PC = 0, 4, 8, 12; RASEmpty=1, RASOverflow=0.
- Jump and stall: PC=0x10, JCout=1, JumpAddr=0x100 -> PC=0x100. Then Stall=1 for 2 cycles with UncondJump=1, JumpAddr=0x200 -> PC holds at 0x100.
- Call/return: at PC=0x20, Call with JumpAddr=0x400 -> PC=0x400, RASEmpty=0. Next cycle, Ret -> PC=0x24, RASEmpty=1.
- Overflow and underflow (RAS_DEPTH=4): 5 nested Calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 -> RASFull=1, RASOverflow=1. 5 Rets -> PC=0x404, 0x304, 0x204, 0x104; the 5th Ret gives PC=Seq and a one-cycle RetUnderflow pulse.
- Wrap and simultaneous events: PC=0xFFFFFFFC with idle -> PC=0x0. Ret+Call with top entry 0x50 at PC=0x80 -> PC=0x50, top entry=0x84, count unchanged.
- Alignment check (PC_ALIGN_CHECK_EN defined): UncondJump with JumpAddr=0x103 -> PC=0x100, MisalignErr pulse. Without the macro: PC=0x103, MisalignErr=0.
